// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS main control FSM: state codes,
// opcodes, mux/ALU select encodings and the packed control word.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_S2 = 2'b11;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_BRANCH = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_src;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       illegal_op;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '0;

    // addi is only a supported opcode when the ADDI states are built in.
    function automatic logic op_supported(input logic [5:0] op);
        logic ok;
        ok = (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
             (op == OP_BEQ) || (op == OP_J);
`ifdef ADDI_EN
        ok = ok || (op == OP_ADDI);
`endif
        return ok;
    endfunction

endpackage

// File: rtl/main_control_fsm_outdec.sv
// Moore output decode for main_control_fsm; only FETCH looks at mem_ready.
// Optional ADDI_EN build adds the ADDIEX/ADDIWB decodes.
module main_control_fsm_outdec
    import mips_ctrl_pkg::*;
(
    input  logic       reset_i,
    input  state_e     state_i,
    input  logic [5:0] opcode_i,
    input  logic       mem_ready_i,
    output ctrl_t      ctrl_o
);

    function automatic ctrl_t fetch_ctrl(input logic grant);
        ctrl_t c;
        c           = CTRL_IDLE;
        c.mem_read  = 1'b1;
        c.alu_src_b = SRCB_FOUR;
        c.alu_op    = ALUOP_ADD;
        c.pc_src    = PCSRC_ALU;
        c.ir_write  = grant;
        c.pc_write  = grant;
        return c;
    endfunction

    always_comb begin
        ctrl_o = CTRL_IDLE;
        // While reset is held, look like an idle FETCH that never commits.
        if (!reset_i) begin
            ctrl_o = fetch_ctrl(1'b0);
        end else begin
            case (state_i)
                S_FETCH: ctrl_o = fetch_ctrl(mem_ready_i);
                S_DECODE: begin
                    ctrl_o.alu_src_b  = SRCB_IMM_S2;
                    ctrl_o.alu_op     = ALUOP_ADD;
                    ctrl_o.illegal_op = !op_supported(opcode_i);
                end
                S_MEMADR: begin
                    ctrl_o.alu_src_a = 1'b1;
                    ctrl_o.alu_src_b = SRCB_IMM;
                    ctrl_o.alu_op    = ALUOP_ADD;
                end
                S_MEMRD: begin
                    ctrl_o.iord     = 1'b1;
                    ctrl_o.mem_read = 1'b1;
                end
                S_MEMWB: begin
                    ctrl_o.mem_to_reg = 1'b1;
                    ctrl_o.reg_write  = 1'b1;
                end
                S_MEMWR: begin
                    ctrl_o.iord      = 1'b1;
                    ctrl_o.mem_write = 1'b1;
                end
                S_EXECUTE: begin
                    ctrl_o.alu_src_a = 1'b1;
                    ctrl_o.alu_src_b = SRCB_REG;
                    ctrl_o.alu_op    = ALUOP_FUNCT;
                end
                S_ALUWB: begin
                    ctrl_o.reg_dst   = 1'b1;
                    ctrl_o.reg_write = 1'b1;
                end
                S_BRANCH: begin
                    ctrl_o.alu_src_a     = 1'b1;
                    ctrl_o.alu_src_b     = SRCB_REG;
                    ctrl_o.alu_op        = ALUOP_SUB;
                    ctrl_o.pc_write_cond = 1'b1;
                    ctrl_o.pc_src        = PCSRC_BRANCH;
                end
                S_JUMP: begin
                    ctrl_o.pc_write = 1'b1;
                    ctrl_o.pc_src   = PCSRC_JUMP;
                end
`ifdef ADDI_EN
                S_ADDIEX: begin
                    ctrl_o.alu_src_a = 1'b1;
                    ctrl_o.alu_src_b = SRCB_IMM;
                    ctrl_o.alu_op    = ALUOP_ADD;
                end
                S_ADDIWB: begin
                    ctrl_o.reg_write = 1'b1;
                end
`endif
                default: ctrl_o = CTRL_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/main_control_fsm.sv
// Multicycle MIPS main control FSM (state register + next-state logic).
// Define ADDI_EN to build in the addi path (ADDIEX/ADDIWB).
//
// state   | meaning
// FETCH   | read instruction, PC+4; waits on mem_ready
// DECODE  | register read, branch target; dispatch on opcode
// MEMADR  | lw/sw effective address
// MEMRD   | data read; waits on mem_ready
// MEMWB   | load writeback
// MEMWR   | data write; waits on mem_ready
// EXECUTE | R-type ALU op
// ALUWB   | R-type writeback
// BRANCH  | beq compare and conditional PC update
// ADDIEX  | addi ALU op (ADDI_EN only)
// ADDIWB  | addi writeback (ADDI_EN only)
// JUMP    | unconditional jump
module main_control_fsm
    import mips_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       PCwrite,
    output logic       PCwrite_cond,
    output logic [1:0] pc_src,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRwrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic       illegal_op,
    output logic [3:0] state
);

    state_e state_q;
    state_e state_d;
    ctrl_t  ctrl;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
`ifdef ADDI_EN
                    OP_ADDI:      state_d = S_ADDIEX;
`endif
                    default:      state_d = S_FETCH;
                endcase
            end
            // opcode still holds the instruction, so it picks load vs store.
            S_MEMADR:  state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   if (mem_ready) state_d = S_MEMWB;
            S_MEMWB:   state_d = S_FETCH;
            S_MEMWR:   if (mem_ready) state_d = S_FETCH;
            S_EXECUTE: state_d = S_ALUWB;
            S_ALUWB:   state_d = S_FETCH;
            S_BRANCH:  state_d = S_FETCH;
            S_JUMP:    state_d = S_FETCH;
`ifdef ADDI_EN
            S_ADDIEX:  state_d = S_ADDIWB;
            S_ADDIWB:  state_d = S_FETCH;
`endif
            default:   state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    main_control_fsm_outdec u_outdec (
        .reset_i     (reset),
        .state_i     (state_q),
        .opcode_i    (opcode),
        .mem_ready_i (mem_ready),
        .ctrl_o      (ctrl)
    );

    assign PCwrite      = ctrl.pc_write;
    assign PCwrite_cond = ctrl.pc_write_cond;
    assign pc_src       = ctrl.pc_src;
    assign IorD         = ctrl.iord;
    assign MemRead      = ctrl.mem_read;
    assign MemWrite     = ctrl.mem_write;
    assign IRwrite      = ctrl.ir_write;
    assign RegDst       = ctrl.reg_dst;
    assign MemtoReg     = ctrl.mem_to_reg;
    assign RegWrite     = ctrl.reg_write;
    assign ALUSrcA      = ctrl.alu_src_a;
    assign ALUSrcB      = ctrl.alu_src_b;
    assign ALUOp        = ctrl.alu_op;
    assign illegal_op   = ctrl.illegal_op;
    assign state        = state_q;

endmodule

// File: tb/tb_main_control_fsm.sv
// Self-checking bench for main_control_fsm: instruction table plus stall/reset sequences.
module tb_main_control_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       PCwrite, PCwrite_cond, IorD, MemRead, MemWrite, IRwrite;
    logic       RegDst, MemtoReg, RegWrite, ALUSrcA, illegal_op;
    logic [1:0] pc_src, ALUSrcB, ALUOp;
    logic [3:0] state;

    always #5 clk = ~clk;

    main_control_fsm dut (
        .clk          (clk),
        .reset        (reset),
        .opcode       (opcode),
        .mem_ready    (mem_ready),
        .PCwrite      (PCwrite),
        .PCwrite_cond (PCwrite_cond),
        .pc_src       (pc_src),
        .IorD         (IorD),
        .MemRead      (MemRead),
        .MemWrite     (MemWrite),
        .IRwrite      (IRwrite),
        .RegDst       (RegDst),
        .MemtoReg     (MemtoReg),
        .RegWrite     (RegWrite),
        .ALUSrcA      (ALUSrcA),
        .ALUSrcB      (ALUSrcB),
        .ALUOp        (ALUOp),
        .illegal_op   (illegal_op),
        .state        (state)
    );

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
    localparam logic [5:0] BEQ = 6'b000100, JMP = 6'b000010, ADDI = 6'b001000;

    logic [16:0] dut_out;
    assign dut_out = {PCwrite, PCwrite_cond, pc_src, IorD, MemRead, MemWrite, IRwrite,
                      RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ALUOp, illegal_op};

    typedef struct {
        string       nm;
        int          st;
        logic [16:0] out;
    } exp_t;

    typedef struct {
        string      nm;
        logic [5:0] op;
        int         len;
        int         st[5];
    } vec_t;

    exp_t sb[$];
    vec_t vecs[8];
    int   checks = 0;
    int   errors = 0;

`ifdef ADDI_EN
    localparam bit ADDI_OK = 1'b1;
`else
    localparam bit ADDI_OK = 1'b0;
`endif

    // Expected outputs straight from the per-state output table.
    function automatic logic [16:0] model(input int st, input logic [5:0] op,
                                          input bit mr, input bit rst_lvl);
        logic pcw = 0, pcc = 0, iord = 0, mrd = 0, mwr = 0, irw = 0;
        logic rdst = 0, m2r = 0, rw = 0, sa = 0, ill = 0;
        logic [1:0] psrc = 2'b00, srcb = 2'b00, aop = 2'b00;
        int s = st;
        bit legal;
        if (!rst_lvl) begin
            s  = 0;
            mr = 1'b0;
        end
        case (s)
            0:  begin mrd = 1; srcb = 2'b01; irw = mr; pcw = mr; end
            1:  begin
                    srcb  = 2'b11;
                    legal = (op == LW) || (op == SW) || (op == RT) || (op == BEQ) ||
                            (op == JMP) || (ADDI_OK && op == ADDI);
                    ill   = !legal;
                end
            2:  begin sa = 1; srcb = 2'b10; end
            3:  begin iord = 1; mrd = 1; end
            4:  begin m2r = 1; rw = 1; end
            5:  begin iord = 1; mwr = 1; end
            6:  begin sa = 1; aop = 2'b10; end
            7:  begin rdst = 1; rw = 1; end
            8:  begin sa = 1; aop = 2'b01; pcc = 1; psrc = 2'b01; end
            9:  if (ADDI_OK) begin sa = 1; srcb = 2'b10; end
            10: if (ADDI_OK) rw = 1;
            11: begin pcw = 1; psrc = 2'b10; end
            default: ;
        endcase
        return {pcw, pcc, psrc, iord, mrd, mwr, irw, rdst, m2r, rw, sa, srcb, aop, ill};
    endfunction

    task automatic check_one();
        exp_t e;
        e = sb.pop_front();
        checks++;
        if (state !== e.st[3:0] || dut_out !== e.out) begin
            errors++;
            $display("FAIL %s: state=%0d outs=%b, required state=%0d outs=%b",
                     e.nm, state, dut_out, e.st, e.out);
        end
        checks++;
        if (PCwrite === 1'b1 && PCwrite_cond === 1'b1) begin
            errors++;
            $display("FAIL %s_pcw_excl: PCwrite=1 PCwrite_cond=1, required not both", e.nm);
        end
    endtask

    task automatic cyc(input string nm, input int st, input logic [5:0] op,
                       input bit mr, input bit rst_lvl);
        exp_t e;
        opcode    = op;
        mem_ready = mr;
        reset     = rst_lvl;
        e.nm  = nm;
        e.st  = st;
        e.out = model(st, op, mr, rst_lvl);
        sb.push_back(e);
        @(negedge clk);
        check_one();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0] = '{nm: "lw",     op: LW,       len: 5, st: '{0, 1, 2, 3, 4}};
        vecs[1] = '{nm: "sw",     op: SW,       len: 4, st: '{0, 1, 2, 5, 0}};
        vecs[2] = '{nm: "rtype",  op: RT,       len: 4, st: '{0, 1, 6, 7, 0}};
        vecs[3] = '{nm: "beq",    op: BEQ,      len: 3, st: '{0, 1, 8, 0, 0}};
        vecs[4] = '{nm: "j",      op: JMP,      len: 3, st: '{0, 1, 11, 0, 0}};
`ifdef ADDI_EN
        vecs[5] = '{nm: "addi",   op: ADDI,     len: 4, st: '{0, 1, 9, 10, 0}};
`else
        vecs[5] = '{nm: "addi",   op: ADDI,     len: 2, st: '{0, 1, 0, 0, 0}};
`endif
        vecs[6] = '{nm: "ill_3f", op: 6'h3f,    len: 2, st: '{0, 1, 0, 0, 0}};
        vecs[7] = '{nm: "ill_01", op: 6'b000001, len: 2, st: '{0, 1, 0, 0, 0}};

        reset     = 1'b0;
        mem_ready = 1'b0;
        opcode    = 6'd0;
        @(posedge clk);
        #1;

        cyc("rst0", 0, RT, 0, 0);
        cyc("rst1", 0, RT, 0, 0);
        cyc("fetch_wait0", 0, RT, 0, 1);
        cyc("fetch_wait1", 0, RT, 0, 1);

        for (int v = 0; v < 8; v++) begin
            for (int k = 0; k < vecs[v].len; k++) begin
                cyc($sformatf("%s_c%0d", vecs[v].nm, k), vecs[v].st[k], vecs[v].op, 1, 1);
            end
        end

        // sw stalled three cycles in MEMWR
        cyc("sws_f", 0, SW, 1, 1);
        cyc("sws_d", 1, SW, 1, 1);
        cyc("sws_a", 2, SW, 0, 1);
        for (int k = 0; k < 3; k++) cyc($sformatf("sws_wait%0d", k), 5, SW, 0, 1);
        cyc("sws_done", 5, SW, 1, 1);

        // reset arriving mid-wait in MEMRD
        cyc("lwr_f", 0, LW, 1, 1);
        cyc("lwr_d", 1, LW, 1, 1);
        cyc("lwr_a", 2, LW, 1, 1);
        cyc("lwr_wait", 3, LW, 0, 1);
        cyc("lwr_rst", 3, LW, 0, 0);
        cyc("lwr_after", 0, LW, 0, 1);

        // reset arriving mid-wait in MEMWR
        cyc("swr_f", 0, SW, 1, 1);
        cyc("swr_d", 1, SW, 1, 1);
        cyc("swr_a", 2, SW, 0, 1);
        cyc("swr_wait", 5, SW, 0, 1);
        cyc("swr_rst", 5, SW, 0, 0);
        cyc("swr_after", 0, SW, 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
